// File: rtl/sc_reg_general.sv
// sc_reg_general: writable register with parallel load, serial shift, sticky written flag and saturating load count
module sc_reg_general #(
    parameter int                       DATAWIDTH_BUS    = 32,
    parameter logic [DATAWIDTH_BUS-1:0] DATA_REGGEN_INIT = '0
) (
    input  logic                     SC_RegGENERAL_CLOCK_50,
    input  logic                     SC_RegGENERAL_RESET_InLow,
    input  logic [DATAWIDTH_BUS-1:0] SC_RegGENERAL_data_InBUS,
    input  logic [1:0]               SC_RegGENERAL_mode_In,
    input  logic                     SC_RegGENERAL_serial_In,
    output logic [DATAWIDTH_BUS-1:0] SC_RegGENERAL_data_OutBUS,
    output logic                     SC_RegGENERAL_written_Out,
    output logic [7:0]               SC_RegGENERAL_loadcount_Out
);
    localparam logic [1:0] MODE_LOAD = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_SHR  = 2'b11;

    logic [DATAWIDTH_BUS-1:0] r, r_next;
    logic                     w, w_next;
    logic [7:0]               c, c_next;

    // next state: load replaces the word, shifts pull the serial bit in at the vacated end
    always_comb begin
        r_next = SC_RegGENERAL_mode_In == MODE_LOAD ? SC_RegGENERAL_data_InBUS :
                 SC_RegGENERAL_mode_In == MODE_SHL  ? {r[DATAWIDTH_BUS-2:0], SC_RegGENERAL_serial_In} :
                 SC_RegGENERAL_mode_In == MODE_SHR  ? {SC_RegGENERAL_serial_In, r[DATAWIDTH_BUS-1:1]} : r;
        w_next = w | (SC_RegGENERAL_mode_In == MODE_LOAD);
        c_next = (SC_RegGENERAL_mode_In == MODE_LOAD && c != 8'hFF) ? c + 8'd1 : c;
    end

    // state updates on the falling edge; reset is sampled there and wins over any mode
    always_ff @(negedge SC_RegGENERAL_CLOCK_50) begin
        if (!SC_RegGENERAL_RESET_InLow) begin
            r <= DATA_REGGEN_INIT;
            w <= 1'b0;
            c <= 8'd0;
        end else begin
            r <= r_next;
            w <= w_next;
            c <= c_next;
        end
    end

    assign SC_RegGENERAL_data_OutBUS   = r;
    assign SC_RegGENERAL_written_Out   = w;
    assign SC_RegGENERAL_loadcount_Out = c;
endmodule

// File: tb/tb_sc_reg_general.sv
// tb_sc_reg_general: directed checks of load, hold, shifts, saturation and synchronous reset
module tb_sc_reg_general;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data = 8'h00;
    logic [1:0] mode = 2'b00;
    logic       serial = 1'b0;
    logic [7:0] q;
    logic       written;
    logic [7:0] cnt;
    int checks = 0;
    int errors = 0;

    sc_reg_general #(.DATAWIDTH_BUS(8), .DATA_REGGEN_INIT(8'hA5)) dut (
        .SC_RegGENERAL_CLOCK_50(clk),
        .SC_RegGENERAL_RESET_InLow(rst_n),
        .SC_RegGENERAL_data_InBUS(data),
        .SC_RegGENERAL_mode_In(mode),
        .SC_RegGENERAL_serial_In(serial),
        .SC_RegGENERAL_data_OutBUS(q),
        .SC_RegGENERAL_written_Out(written),
        .SC_RegGENERAL_loadcount_Out(cnt)
    );

    always #5 clk = ~clk;

    // advance one active (falling) edge and settle before sampling
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mode = 2'b01; data = 8'h3C;
        tick();
        tick();
        checks++; if (q !== 8'hA5) begin errors++; $display("FAIL reset_data got %h exp a5", q); end
        checks++; if (written !== 1'b0) begin errors++; $display("FAIL reset_written got %b exp 0", written); end
        checks++; if (cnt !== 8'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", cnt); end
    endtask

    task automatic test_load_hold();
        rst_n = 1'b1; mode = 2'b01; data = 8'h3C;
        tick();
        checks++; if (q !== 8'h3C) begin errors++; $display("FAIL load_data got %h exp 3c", q); end
        checks++; if (written !== 1'b1) begin errors++; $display("FAIL load_written got %b exp 1", written); end
        checks++; if (cnt !== 8'd1) begin errors++; $display("FAIL load_count got %0d exp 1", cnt); end
        mode = 2'b00; data = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (q !== 8'h3C) begin errors++; $display("FAIL hold_data[%0d] got %h exp 3c", i, q); end
            checks++; if (written !== 1'b1) begin errors++; $display("FAIL hold_written[%0d] got %b exp 1", i, written); end
            checks++; if (cnt !== 8'd1) begin errors++; $display("FAIL hold_count[%0d] got %0d exp 1", i, cnt); end
        end
    endtask

    task automatic test_shifts();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        mode = 2'b01; data = 8'h81; tick();
        mode = 2'b10; serial = 1'b0; tick();
        checks++; if (q !== 8'h02) begin errors++; $display("FAIL shl_data got %h exp 02", q); end
        checks++; if (cnt !== 8'd1) begin errors++; $display("FAIL shl_count got %0d exp 1", cnt); end
        mode = 2'b11; serial = 1'b1; tick();
        checks++; if (q !== 8'h81) begin errors++; $display("FAIL shr1_data got %h exp 81", q); end
        tick();
        checks++; if (q !== 8'hC0) begin errors++; $display("FAIL shr2_data got %h exp c0", q); end
        checks++; if (cnt !== 8'd1) begin errors++; $display("FAIL shr_count got %0d exp 1", cnt); end
        checks++; if (written !== 1'b1) begin errors++; $display("FAIL shr_written got %b exp 1", written); end
    endtask

    task automatic test_shift_no_load();
        rst_n = 1'b0; mode = 2'b00; tick(); rst_n = 1'b1;
        mode = 2'b10; serial = 1'b1; tick();
        checks++; if (q !== 8'h4B) begin errors++; $display("FAIL shift_noload_data got %h exp 4b", q); end
        checks++; if (written !== 1'b0) begin errors++; $display("FAIL shift_noload_written got %b exp 0", written); end
        checks++; if (cnt !== 8'd0) begin errors++; $display("FAIL shift_noload_count got %0d exp 0", cnt); end
    endtask

    task automatic test_saturation();
        rst_n = 1'b0; mode = 2'b00; tick(); rst_n = 1'b1;
        mode = 2'b01;
        for (int i = 0; i < 300; i++) begin
            data = i[7:0];
            tick();
            if (i == 253) begin
                checks++; if (cnt !== 8'd254) begin errors++; $display("FAIL sat_count254 got %0d exp 254", cnt); end
            end
            if (i == 254) begin
                checks++; if (cnt !== 8'd255) begin errors++; $display("FAIL sat_count255 got %0d exp 255", cnt); end
            end
        end
        checks++; if (cnt !== 8'd255) begin errors++; $display("FAIL sat_count_hold got %0d exp 255", cnt); end
        checks++; if (q !== 8'h2B) begin errors++; $display("FAIL sat_data got %h exp 2b", q); end
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0; mode = 2'b00; tick(); rst_n = 1'b1;
        mode = 2'b01; data = 8'h3C; tick();
        mode = 2'b10; serial = 1'b0; tick();
        checks++; if (q !== 8'h78) begin errors++; $display("FAIL mid_shift1 got %h exp 78", q); end
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        checks++; if (q !== 8'hF0) begin errors++; $display("FAIL mid_pulse_data got %h exp f0", q); end
        checks++; if (cnt !== 8'd1) begin errors++; $display("FAIL mid_pulse_count got %0d exp 1", cnt); end
        checks++; if (written !== 1'b1) begin errors++; $display("FAIL mid_pulse_written got %b exp 1", written); end
        rst_n = 1'b0; tick();
        checks++; if (q !== 8'hA5) begin errors++; $display("FAIL mid_reset_data got %h exp a5", q); end
        checks++; if (written !== 1'b0) begin errors++; $display("FAIL mid_reset_written got %b exp 0", written); end
        checks++; if (cnt !== 8'd0) begin errors++; $display("FAIL mid_reset_count got %0d exp 0", cnt); end
        rst_n = 1'b1; tick();
        checks++; if (q !== 8'h4A) begin errors++; $display("FAIL mid_resume got %h exp 4a", q); end
    endtask

    initial begin
        test_reset();
        test_load_hold();
        test_shifts();
        test_shift_no_load();
        test_saturation();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout checks %0d errors %0d", checks, errors);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/sc_reg_general.md
# sc_reg_general

Writable general-purpose datapath register, the write-side counterpart of the constant-source fixed registers in the register bank. It captures a word from the CPU data bus, or shifts serially, on the falling clock edge under a 2-bit mode select. It drives its contents back onto a register output bus. It also keeps a sticky written flag and a saturating count of parallel loads for the control unit and debug.

## Interface

- DATAWIDTH_BUS, 32, width of the data buses and of the register (minimum 2)
- DATA_REGGEN_INIT, 32'b0, register value after reset (DATAWIDTH_BUS bits)

- SC_RegGENERAL_CLOCK_50  in  1  system clock. All state updates on the falling edge.
- SC_RegGENERAL_RESET_InLow  in  1  synchronous, active-low reset, sampled on the falling clock edge
- SC_RegGENERAL_data_InBUS  in  DATAWIDTH_BUS  parallel load data from the CPU data bus
- SC_RegGENERAL_mode_In  in  2  operation select: 00 hold, 01 parallel load, 10 shift left, 11 shift right
- SC_RegGENERAL_serial_In  in  1  serial bit shifted in during modes 10/11
- SC_RegGENERAL_data_OutBUS  out  DATAWIDTH_BUS  current register contents
- SC_RegGENERAL_written_Out  out  1  sticky flag: at least one parallel load since reset
- SC_RegGENERAL_loadcount_Out  out  8  saturating count of parallel loads since reset

## Operation

- Internal state:
  - data register R (DATAWIDTH_BUS bits)
  - written flag W
  - load counter C (8 bits)
- Next-state logic is combinational from mode, inputs and current state. Registers update only on the falling edge.
- Reset (RESET_InLow = 0 at a falling edge):
  - R <= DATA_REGGEN_INIT, W <= 0, C <= 0.
  - Reset overrides every mode value.
- Mode 00, hold: R, W and C unchanged.
- Mode 01, parallel load:
  - R <= data_InBUS.
  - W <= 1.
  - C <= C+1 if C < 255, else C stays at 255 (saturates, never wraps).
- Mode 10, shift left: R <= {R[W-2:0], serial_In}. The MSB is discarded. W and C unchanged.
- Mode 11, shift right logical: R <= {serial_In, R[W-1:1]}. The LSB is discarded. W and C unchanged.
- Only mode 01 affects W and C. Shifts never set W.
- data_OutBUS = R, written_Out = W, loadcount_Out = C. These are pure combinational copies of the state, with no extra logic.
- No X propagation: each mode value has a defined next state. Undriven mode bits are not a supported input.

## Timing

- Latency: an operation selected before a falling edge is visible on the outputs immediately after that edge, with one falling edge of latency. There is no bus turnaround cycle.
- Inputs must be stable around the falling edge. The rising edge has no function in this block.
- Reset is synchronous:
  - Asserting RESET_InLow between edges has no effect until the next falling edge.
  - Deasserting it takes effect at the first falling edge where it is sampled high.
  - The mode present at that edge executes normally.
- Output values during and after reset: data_OutBUS = DATA_REGGEN_INIT, written_Out = 0, loadcount_Out = 0.
- Reset during a shift or load sequence aborts it. The next sequence restarts from DATA_REGGEN_INIT.
- Back-to-back loads on consecutive falling edges each count, and each overwrites R.
- The counter saturates at 255: a load at 255 updates R and leaves C at 255.
- Mode changes between edges have no effect. Only the value sampled at the edge matters.

## Test plan

All scenarios use DATAWIDTH_BUS = 8 and DATA_REGGEN_INIT = 8'hA5.

- Reset: hold RESET_InLow = 0 for 2 falling edges with mode 01 and data 8'h3C.
  - Required: data_OutBUS = 8'hA5, written_Out = 0, loadcount_Out = 0.
  - Required: no load occurs while reset is held.
- Load then hold: release reset, mode 01 with data 8'h3C for 1 edge, then mode 00 for 3 edges.
  - Required after the load edge: data_OutBUS = 8'h3C, written_Out = 1, loadcount_Out = 1.
  - Required: all three values unchanged through the hold edges.
- Shifts: after loading 8'h81, apply mode 10 with serial_In = 0 for 1 edge.
  - Required: 8'h02.
  - Then mode 11 with serial_In = 1 for 2 edges. Required: 8'h81, then 8'hC0.
  - Required throughout: loadcount_Out stays 1.
- Shift without load: after reset, apply mode 10 with serial_In = 1 for 1 edge.
  - Required: data_OutBUS = 8'h4B, written_Out = 0, loadcount_Out = 0.
- Saturation: 300 consecutive mode 01 edges with incrementing data.
  - Required: loadcount_Out reaches 255 and holds.
  - Required: data_OutBUS equals the last data applied (8'h2B for data = index mod 256).
- Reset mid-operation: during a mode 10 sequence, pulse RESET_InLow low between edges, then drive it low across one edge.
  - Required: the between-edge pulse has no effect.
  - Required on the edge where reset is sampled low: data_OutBUS = 8'hA5, written_Out = 0, loadcount_Out = 0.
  - Required: the shift resumes from 8'hA5 at the next edge after release.
